// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// next-PC select codes and the default reset PC.
package inst_fetch_unit_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } ifu_state_e;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } npc_sel_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/ifu_next_pc.sv
// Combinational next-PC selection for the fetch unit.
// Priority is Jr over Jump over taken Branch over sequential.
module ifu_next_pc
    import inst_fetch_unit_pkg::*;
(
    input  logic [31:0] pc_i,
    input  logic [25:0] ir_i,
    input  logic        jump_i,
    input  logic        jr_i,
    input  logic        branch_i,
    input  logic        branch_taken_i,
    input  logic [31:0] jr_target_i,
    output logic [31:0] pc4_o,
    output logic [31:0] next_pc_o
);

    npc_sel_e    sel;
    logic [31:0] br_off;

    assign pc4_o  = pc_i + 32'd4;
    assign br_off = {{14{ir_i[15]}}, ir_i[15:0], 2'b00};

    always_comb begin
        sel = SEL_SEQ;
        // Jalr raises Jr and Jump together; the register target must win.
        if (jr_i)
            sel = SEL_JR;
        else if (jump_i)
            sel = SEL_J;
        else if (branch_i && branch_taken_i)
            sel = SEL_BR;
    end

    always_comb begin
        next_pc_o = pc4_o;
        case (sel)
            SEL_JR:  next_pc_o = jr_target_i & 32'hFFFF_FFFC;
            SEL_J:   next_pc_o = {pc4_o[31:28], ir_i, 2'b00};
            SEL_BR:  next_pc_o = pc4_o + br_off;
            default: next_pc_o = pc4_o;
        endcase
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Multicycle MIPS instruction fetch unit: owns PC and IR, fetches through the
// stalling I-cache port. Define IFU_PERF_EN to add fetch/stall perf counters.
module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    output logic        ICACHE_ren,
    output logic [29:0] ICACHE_addr,
    input  logic        ICACHE_stall,
    input  logic [31:0] ICACHE_rdata,
    output logic [31:0] inst,
    output logic [5:0]  Op,
    output logic [5:0]  FuncField,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] link_addr,
    input  logic        hold_in,
    input  logic        Jump,
    input  logic        Jr,
    input  logic        Branch,
    input  logic        branch_taken,
    input  logic [31:0] jr_target
`ifdef IFU_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    ifu_state_e  state_q;
    logic [31:0] pc_q;
    logic [31:0] ir_q;
    logic        valid_q;
    logic        ren_q;
    logic [31:0] pc_d;
    logic [31:0] pc4;

    ifu_next_pc u_next_pc (
        .pc_i           (pc_q),
        .ir_i           (ir_q[25:0]),
        .jump_i         (Jump),
        .jr_i           (Jr),
        .branch_i       (Branch),
        .branch_taken_i (branch_taken),
        .jr_target_i    (jr_target),
        .pc4_o          (pc4),
        .next_pc_o      (pc_d)
    );

`ifdef IFU_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
`endif

    // The request is a registered copy of "next state is FETCH", so reset
    // drops it at once and abandons any stalled access.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            ir_q    <= 32'd0;
            valid_q <= 1'b0;
            ren_q   <= 1'b0;
`ifdef IFU_PERF_EN
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
`endif
        end else begin
            case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    ren_q   <= 1'b1;
                end
                FETCH: begin
                    if (!ICACHE_stall) begin
                        ir_q    <= ICACHE_rdata;
                        valid_q <= 1'b1;
                        ren_q   <= 1'b0;
                        state_q <= HOLD;
`ifdef IFU_PERF_EN
                        if (fetch_cnt_q != 32'hFFFF_FFFF)
                            fetch_cnt_q <= fetch_cnt_q + 32'd1;
`endif
                    end
`ifdef IFU_PERF_EN
                    else if (stall_cnt_q != 32'hFFFF_FFFF) begin
                        stall_cnt_q <= stall_cnt_q + 32'd1;
                    end
`endif
                end
                HOLD: begin
                    if (!hold_in) begin
                        pc_q    <= pc_d;
                        valid_q <= 1'b0;
                        ren_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= BOOT;
                    ren_q   <= 1'b0;
                end
            endcase
        end
    end

    assign ICACHE_ren  = ren_q;
    assign ICACHE_addr = pc_q[31:2];
    assign inst        = ir_q;
    assign Op          = ir_q[31:26];
    assign FuncField   = ir_q[5:0];
    assign inst_valid  = valid_q;
    assign pc          = pc_q;
    assign link_addr   = pc4;

`ifdef IFU_PERF_EN
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: hand sequences for reset, stall,
// hold and reset-abort, plus a table of redirect vectors scored through a queue.
module tb_inst_fetch_unit;

    logic        clk;
    logic        rst;
    logic        ICACHE_ren;
    logic [29:0] ICACHE_addr;
    logic        ICACHE_stall;
    logic [31:0] ICACHE_rdata;
    logic [31:0] inst;
    logic [5:0]  Op;
    logic [5:0]  FuncField;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        hold_in;
    logic        Jump;
    logic        Jr;
    logic        Branch;
    logic        branch_taken;
    logic [31:0] jr_target;
`ifdef IFU_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] word;
        logic        j;
        logic        jr;
        logic        br;
        logic        tk;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
        logic [31:0] exp_link;
    } vec_t;

    vec_t vecs[9];

    inst_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .ICACHE_ren   (ICACHE_ren),
        .ICACHE_addr  (ICACHE_addr),
        .ICACHE_stall (ICACHE_stall),
        .ICACHE_rdata (ICACHE_rdata),
        .inst         (inst),
        .Op           (Op),
        .FuncField    (FuncField),
        .inst_valid   (inst_valid),
        .pc           (pc),
        .link_addr    (link_addr),
        .hold_in      (hold_in),
        .Jump         (Jump),
        .Jr           (Jr),
        .Branch       (Branch),
        .branch_taken (branch_taken),
        .jr_target    (jr_target)
`ifdef IFU_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Precondition: DUT in FETCH. Leaves DUT in HOLD holding 'word'.
    task automatic fetch(input logic [31:0] word, input int stalls);
        logic [31:0] a0;
        logic [31:0] ir0;
        a0  = {2'b00, ICACHE_addr};
        ir0 = inst;
        chk("fetch_ren", {31'd0, ICACHE_ren}, 32'd1);
        for (int i = 0; i < stalls; i++) begin
            ICACHE_stall = 1'b1;
            ICACHE_rdata = 32'hDEAD_BEEF;
            tick();
            chk("stall_addr", {2'b00, ICACHE_addr}, a0);
            chk("stall_ren", {31'd0, ICACHE_ren}, 32'd1);
            chk("stall_ir", inst, ir0);
        end
        ICACHE_stall = 1'b0;
        ICACHE_rdata = word;
        tick();
        chk("fetch_ir", inst, word);
        chk("fetch_valid", {31'd0, inst_valid}, 32'd1);
        chk("fetch_ren_off", {31'd0, ICACHE_ren}, 32'd0);
        chk("fetch_op", {26'd0, Op}, {26'd0, word[31:26]});
        chk("fetch_func", {26'd0, FuncField}, {26'd0, word[5:0]});
        $display("fetch pc=%h word=%h stalls=%0d", pc, word, stalls);
    endtask

    // Precondition: DUT in HOLD. Releases for one cycle with the given redirect.
    task automatic redirect(input logic j, input logic jr, input logic br, input logic tk,
                            input logic [31:0] tgt, input logic [31:0] exp_pc);
        logic [31:0] e;
        exp_q.push_back(exp_pc);
        Jump = j; Jr = jr; Branch = br; branch_taken = tk; jr_target = tgt;
        hold_in = 1'b0;
        tick();
        hold_in = 1'b1;
        Jump = 1'b0; Jr = 1'b0; Branch = 1'b0; branch_taken = 1'b0; jr_target = 32'd0;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL scoreboard_empty: got none expected entry");
        end else begin
            e = exp_q.pop_front();
            chk("npc", pc, e);
            chk("npc_addr", {2'b00, ICACHE_addr}, {2'b00, e[31:2]});
            chk("npc_ren", {31'd0, ICACHE_ren}, 32'd1);
            chk("npc_valid", {31'd0, inst_valid}, 32'd0);
            $display("redirect J=%0b Jr=%0b Br=%0b tk=%0b -> pc=%h", j, jr, br, tk, pc);
        end
    endtask

    initial begin
        logic [31:0] pc_s;
        logic [31:0] ir_s;

        vecs[0] = '{32'h0000_0040, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_003C, 32'h0000_0044};
        vecs[1] = '{32'h0000_0040, 32'h1000_FFFE, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0000_0044, 32'h0000_0044};
        vecs[2] = '{32'h1000_0000, 32'h0800_0010, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h1000_0040, 32'h1000_0004};
        vecs[3] = '{32'h0000_0200, 32'h0060_F809, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_0123, 32'h0000_0120, 32'h0000_0204};
        vecs[4] = '{32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000, 32'h0000_0000};
        vecs[5] = '{32'h0000_0100, 32'h1000_0003, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 32'h0000_0110, 32'h0000_0104};
        vecs[6] = '{32'h0000_0100, 32'h1000_0003, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_0104, 32'h0000_0104};
        vecs[7] = '{32'h2000_0000, 32'h0800_0004, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'h2000_0010, 32'h2000_0004};
        vecs[8] = '{32'h0000_0300, 32'h03E0_0008, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0007, 32'h8000_0004, 32'h0000_0304};

        rst = 1'b1; ICACHE_stall = 1'b0; ICACHE_rdata = 32'd0; hold_in = 1'b1;
        Jump = 1'b0; Jr = 1'b0; Branch = 1'b0; branch_taken = 1'b0; jr_target = 32'd0;

        // Reset values and first fetch
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_ir", inst, 32'h0);
        chk("rst_op", {26'd0, Op}, 32'h0);
        chk("rst_func", {26'd0, FuncField}, 32'h0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_ren", {31'd0, ICACHE_ren}, 32'd0);
        chk("rst_addr", {2'b00, ICACHE_addr}, 32'h0);
        chk("rst_link", link_addr, 32'h4);
        rst = 1'b0;
        chk("boot_ren", {31'd0, ICACHE_ren}, 32'd0);
        tick();
        chk("first_ren", {31'd0, ICACHE_ren}, 32'd1);
        chk("first_addr", {2'b00, ICACHE_addr}, 32'h0);
        fetch(32'h2008_0005, 0);
        chk("first_op", {26'd0, Op}, 32'h08);
        redirect(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4);

        // Stall sequence at pc=8
        fetch(32'h0000_0000, 0);
        redirect(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h8);
        chk("stall_start_addr", {2'b00, ICACHE_addr}, 32'h2);
        fetch(32'h0000_0020, 3);
`ifdef IFU_PERF_EN
        chk("perf_stall", perf_stall_cnt, 32'd3);
        chk("perf_fetch", perf_fetch_cnt, 32'd3);
`endif

        // hold_in keeps everything frozen
        pc_s = pc;
        ir_s = inst;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_pc", pc, pc_s);
            chk("hold_ir", inst, ir_s);
            chk("hold_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_ren", {31'd0, ICACHE_ren}, 32'd0);
        end
        redirect(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'hC);
        chk("seq_link", link_addr, 32'h10);
        fetch(32'h0000_0000, 0);

        // Table of redirect vectors
        for (int v = 0; v < 9; v++) begin
            redirect(1'b0, 1'b1, 1'b0, 1'b0, vecs[v].start_pc, vecs[v].start_pc);
            fetch(vecs[v].word, v % 2);
            chk("vec_link", link_addr, vecs[v].exp_link);
            redirect(vecs[v].j, vecs[v].jr, vecs[v].br, vecs[v].tk, vecs[v].tgt, vecs[v].exp_pc);
            fetch(32'h0000_0000, 0);
        end

        // Reset during a stalled fetch
        redirect(1'b0, 1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0000_0500);
        ICACHE_stall = 1'b1;
        tick();
        chk("pre_rst_ren", {31'd0, ICACHE_ren}, 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_ren", {31'd0, ICACHE_ren}, 32'd0);
        chk("async_rst_pc", pc, 32'h0);
        chk("async_rst_valid", {31'd0, inst_valid}, 32'd0);
`ifdef IFU_PERF_EN
        chk("rst_perf_fetch", perf_fetch_cnt, 32'd0);
        chk("rst_perf_stall", perf_stall_cnt, 32'd0);
`endif
        tick();
        rst = 1'b0;
        ICACHE_stall = 1'b0;
        chk("reboot_ren", {31'd0, ICACHE_ren}, 32'd0);
        tick();
        chk("refetch_ren", {31'd0, ICACHE_ren}, 32'd1);
        chk("refetch_addr", {2'b00, ICACHE_addr}, 32'h0);
        fetch(32'h1234_5678, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch unit for the multicycle MIPS core. It owns the program counter and issues word reads to the instruction cache using the cache's stall handshake. It holds the fetched word and presents it, with its opcode and function fields, to the Control decoder. It then applies the decoder's Jump/Jr/Branch outcome to select the next PC.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `ICACHE_ren` output 1: instruction read request.
- `ICACHE_addr` output 30: word address, equal to `pc[31:2]`.
- `ICACHE_stall` input 1: cache busy. `ICACHE_rdata` is valid in any cycle where `ICACHE_ren`=1 and stall=0.
- `ICACHE_rdata` input 32: instruction word.
- `inst` output 32: held instruction register (IR).
- `Op` output 6: `IR[31:26]`, drives the decoder.
- `FuncField` output 6: `IR[5:0]`, drives the decoder.
- `inst_valid` output 1: IR holds the instruction at `pc`.
- `pc` output 32: address of the held instruction.
- `link_addr` output 32: pc+4, used for Jal/Jalr writeback.
- `hold_in` input 1: datapath/hazard hold. While high, the IR is kept and no redirect is taken.
- `Jump`, `Jr`, `Branch` input 1 each: decoder outputs for the held instruction.
- `branch_taken` input 1: ALU zero result qualified for beq.
- `jr_target` input 32: register rs value.

## Operation
- FSM states are BOOT, FETCH and HOLD. Reset state is BOOT.
- BOOT: `ICACHE_ren`=0. Unconditionally moves to FETCH next cycle.
- FETCH: `ICACHE_ren`=1 and `ICACHE_addr`=`pc[31:2]`.
  - stall=1: remain in FETCH with request and address unchanged.
  - stall=0: latch rdata into IR, set `inst_valid`=1, go to HOLD.
- HOLD: `ICACHE_ren`=0 and `inst_valid`=1.
  - `hold_in`=1: remain, with IR and pc frozen.
  - `hold_in`=0: load pc with next_pc, clear `inst_valid`, go to FETCH.
- next_pc priority, highest first:
  - Jr → `jr_target`. Jalr asserts Jr and Jump together, so Jr wins.
  - Jump → `{pc4[31:28], IR[25:0], 2'b00}`.
  - Branch & branch_taken → pc4 + (sign-extended `IR[15:0]` << 2).
  - Otherwise → pc4.
- pc4 = pc + 32'd4. All adds are modulo 2^32, so pc 32'hFFFF_FFFC advances to 0.
- `jr_target[1:0]` is ignored and forced to 00.
- Branch without branch_taken falls through to pc4.
- `link_addr` is pc4 at all times.

## Timing
- Reset values: pc=RESET_PC, IR=0, Op=0, FuncField=0, inst_valid=0, ICACHE_ren=0, ICACHE_addr=RESET_PC[31:2], link_addr=RESET_PC+4.
- Minimum instruction period is 2 cycles (FETCH with zero stall, then HOLD). Each stall cycle and each `hold_in` cycle adds one.
- IR, Op and FuncField change only on the FETCH→HOLD edge.
- pc changes only on the HOLD→FETCH edge.
- Redirect inputs are sampled only in HOLD with `hold_in`=0; they are don't-care elsewhere.
- Reset asserted mid-FETCH (stall high) drops `ICACHE_ren` immediately and abandons the request. After release: one BOOT cycle, then a fetch at RESET_PC.

## Configuration
- Macro `IFU_PERF_EN`.
- When defined, adds two output ports, each cleared by reset and saturating at all-ones:
  - `perf_fetch_cnt` (32): increments on each FETCH→HOLD transition.
  - `perf_stall_cnt` (32): increments on each FETCH cycle with `ICACHE_stall`=1.
- When undefined, neither port nor the counters exist, and all other behaviour is identical.

## Structure
- Shared package holds:
  - FSM state encoding: BOOT=2'd0, FETCH=2'd1, HOLD=2'd2.
  - next-pc select constants: SEL_SEQ, SEL_BR, SEL_J, SEL_JR.
  - RESET_PC default.
- One combinational sub-module, `ifu_next_pc`, computes next_pc from pc, IR and the redirect inputs. The FSM, PC, IR and counters stay in the top.

## Test plan
- Reset release, stall=0, rdata=32'h2008_0005 → ICACHE_ren low for 1 cycle, then addr=0; next cycle inst_valid=1 and Op=6'b001000; then pc=4.
- Fetch at pc=8 with stall held 3 cycles → addr constant at 2 for 4 cycles; IR loads only on the stall=0 cycle; perf_stall_cnt=3 with IFU_PERF_EN defined.
- beq at pc=32'h40 with IR[15:0]=16'hFFFE, Branch=1 and branch_taken=1 → next pc=32'h3C; with branch_taken=0 → 32'h44.
- j at pc=32'h1000_0000 with IR[25:0]=26'h0000_010 → next pc=32'h1000_0040. Jalr (Jr=1, Jump=1) with jr_target=32'h0000_0123 → next pc=32'h0000_0120 and link_addr=pc+4.
- hold_in=1 for 5 cycles in HOLD → pc, IR and inst_valid stable; then hold_in=0 → FETCH at pc+4. Also pc=32'hFFFF_FFFC sequential → next pc=0.
- rst asserted during a stalled FETCH → ICACHE_ren=0 and pc=RESET_PC immediately; refetch at RESET_PC after one BOOT cycle.
